// File: rtl/naive_bus_ram_slave.sv
// naive_bus_ram_slave
//   Single-port, byte-writable 32-bit SRAM on the responder side of naive_bus.
//   It decodes only the word index addr[ADDR_BITS+1:2]. Upper address bits are
//   ignored, so out-of-capacity addresses alias onto the array.
//   Optional wait-state engine: define NAIVE_RAM_WAIT_STATE_EN to build an
//   IDLE/RD_WAIT/WR_WAIT FSM that delays every grant by WAIT_CYCLES+1 cycles.
//   Without the macro, every access is granted in the cycle it is requested.
//
// Parameters
//   ADDR_BITS   : word-address bits (capacity 2^ADDR_BITS words)
//   WAIT_CYCLES : extra cycles before a grant, 0..15 (wait-state build only)
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-high
//   rd_req   : read request; held with rd_addr until rd_gnt
//   rd_be    : read byte enables (ignored, the full word is returned)
//   rd_addr  : read byte address
//   wr_req   : write request; held with wr_addr/wr_be/wr_data until wr_gnt
//   wr_be    : write byte-lane enables
//   wr_addr  : write byte address
//   wr_data  : write data
//   rd_gnt   : read grant (combinational)
//   wr_gnt   : write grant (combinational)
//   rd_data  : read data, valid the cycle after rd_gnt, held until the next read
module naive_bus_ram_slave #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [3:0]  rd_be,
    input  logic [31:0] rd_addr,
    input  logic        wr_req,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        rd_gnt,
    output logic        wr_gnt,
    output logic [31:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem_r [DEPTH];
    logic [31:0]          rd_data_r;
    logic [ADDR_BITS-1:0] rd_idx_s;
    logic [ADDR_BITS-1:0] wr_idx_s;
    logic                 rd_gnt_s;
    logic                 wr_gnt_s;

    assign rd_idx_s = rd_addr[ADDR_BITS+1:2];
    assign wr_idx_s = wr_addr[ADDR_BITS+1:2];

    // Byte-lane selection and read byte enables are not needed by the array.
    logic unused_s;
    assign unused_s = ^{rd_be, rd_addr[31:ADDR_BITS+2], rd_addr[1:0],
                        wr_addr[31:ADDR_BITS+2], wr_addr[1:0]};

`ifdef NAIVE_RAM_WAIT_STATE_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    state_e     state_r;
    state_e     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    // Wait-state FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, counter and grant decode; grants fire in the cycle cnt==1.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rd_gnt_s    = 1'b0;
        wr_gnt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (WAIT_CNT == 4'd0) begin
                    // No wait states: grant immediately, reads first.
                    rd_gnt_s = rd_req;
                    wr_gnt_s = wr_req & ~rd_req;
                end else if (rd_req) begin
                    cnt_nxt_s   = WAIT_CNT;
                    state_nxt_s = ST_RD_WAIT;
                end else if (wr_req) begin
                    cnt_nxt_s   = WAIT_CNT;
                    state_nxt_s = ST_WR_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (!rd_req) begin
                    // Master withdrew: abort without touching the array.
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r > 4'd1) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    rd_gnt_s    = 1'b1;
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (!wr_req) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r > 4'd1) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    wr_gnt_s    = 1'b1;
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                cnt_nxt_s   = 4'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end
`else
    logic [3:0] unused_wait_s;
    assign unused_wait_s = 4'(WAIT_CYCLES);

    // Zero-wait responder: reads win over a simultaneous write.
    always_comb begin
        rd_gnt_s = rd_req;
        wr_gnt_s = wr_req & ~rd_req;
    end
`endif

    // Reset forces both grants low immediately, independent of the clock.
    assign rd_gnt  = rd_gnt_s & ~rst;
    assign wr_gnt  = wr_gnt_s & ~rst;
    assign rd_data = rd_data_r;

    // Byte-masked array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_gnt) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_idx_s][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read data register, loaded only on a read grant and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= 32'h0000_0000;
        end else if (rd_gnt) begin
            rd_data_r <= mem_r[rd_idx_s];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

endmodule

// File: tb/tb_naive_bus_ram_slave.sv
module tb_naive_bus_ram_slave;

    localparam int WAIT = 3;
`ifdef NAIVE_RAM_WAIT_STATE_EN
    localparam int LAT = WAIT + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_gnt;
    logic        wr_gnt;
    logic [31:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;

    naive_bus_ram_slave #(
        .ADDR_BITS   (4),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_be   (rd_be),
        .rd_addr (rd_addr),
        .wr_req  (wr_req),
        .wr_be   (wr_be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_gnt  (rd_gnt),
        .wr_gnt  (wr_gnt),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the granting edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input string tag);
        int  lat;
        logic got;
        lat = 0;
        got = 1'b0;
        wr_req = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            check_eq({tag, "_no_rd_gnt"}, {31'd0, rd_gnt}, 32'd0);
            if (wr_gnt) got = 1'b1;
            @(posedge clk); #1;
        end
        wr_req = 1'b0;
        check_eq({tag, "_wr_lat"}, lat, LAT);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input string tag);
        int  lat;
        logic got;
        logic [31:0] prev;
        lat = 0;
        got = 1'b0;
        prev = rd_data;
        rd_req = 1'b1; rd_addr = addr; rd_be = 4'hF;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            check_eq({tag, "_no_wr_gnt"}, {31'd0, wr_gnt}, 32'd0);
            if (rd_gnt) got = 1'b1;
            else check_eq({tag, "_hold"}, rd_data, prev);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        check_eq({tag, "_rd_lat"}, lat, LAT);
        @(negedge clk);
        check_eq({tag, "_data"}, rd_data, exp_data);
        @(posedge clk); #1;
    endtask

    initial begin
        int rc;
        int wc;
        int cyc;

        rst = 1'b1;
        rd_req = 1'b0; rd_be = 4'h0; rd_addr = 32'h0;
        wr_req = 1'b0; wr_be = 4'h0; wr_addr = 32'h0; wr_data = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
        check_eq("rst_wr_gnt", {31'd0, wr_gnt}, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read
        do_write(32'h10, 32'hDEADBEEF, 4'hF, "t1");
        do_read (32'h10, 32'hDEADBEEF, "t1");

        // Byte-enable masking, and a be=0 write that changes nothing
        do_write(32'h20, 32'h11223344, 4'hF, "t2pre");
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, "t2be");
        do_read (32'h20, 32'h11BB33DD, "t2");
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000, "t2be0");
        do_read (32'h20, 32'h11BB33DD, "t2b");

        // Aliasing: with 4 index bits, 0x44 maps onto word 1 (0x04)
        do_write(32'h44, 32'hCAFEF00D, 4'hF, "alias");
        do_read (32'h04, 32'hCAFEF00D, "alias");

        // Simultaneous read and write: read first, write a full wait later
        rc = 0; wc = 0; cyc = 0;
        rd_req = 1'b1; rd_addr = 32'h10;
        wr_req = 1'b1; wr_addr = 32'h30; wr_data = 32'h12345678; wr_be = 4'hF;
        while ((rc == 0 || wc == 0) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            check_eq("sim_not_both", {31'd0, rd_gnt & wr_gnt}, 32'd0);
            if (rd_gnt && rc == 0) rc = cyc;
            if (wr_gnt && wc == 0) wc = cyc;
            @(posedge clk); #1;
            if (rc != 0) rd_req = 1'b0;
            if (wc != 0) wr_req = 1'b0;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        check_eq("sim_rd_cycle", rc, LAT);
        check_eq("sim_wr_cycle", wc, 2 * LAT);
        check_eq("sim_rd_data", rd_data, 32'hDEADBEEF);
        do_read(32'h30, 32'h12345678, "sim_wr_vis");

`ifdef NAIVE_RAM_WAIT_STATE_EN
        // Abort: drop wr_req while cnt==2 (third cycle of the request)
        wr_req = 1'b1; wr_addr = 32'h20; wr_data = 32'h00000000; wr_be = 4'hF;
        repeat (2) begin
            @(negedge clk);
            check_eq("abort_no_gnt", {31'd0, wr_gnt}, 32'd0);
            @(posedge clk); #1;
        end
        wr_req = 1'b0;
        @(negedge clk);
        check_eq("abort_dropped", {31'd0, wr_gnt}, 32'd0);
        @(posedge clk); #1;
        do_read(32'h20, 32'h11BB33DD, "abort_mem");
`endif

        // Reset mid-request: grants and rd_data drop at once, array preserved
        rd_req = 1'b1; rd_addr = 32'h04; rd_be = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rstmid_rd_gnt", {31'd0, rd_gnt}, 32'd0);
        check_eq("rstmid_rd_data", rd_data, 32'h0);
        @(posedge clk); #1;
        rd_req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(32'h10, 32'hDEADBEEF, "rstmid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/naive_bus_ram_slave.md
# naive_bus_ram_slave

Single-port, byte-writable SRAM that answers on the responder side of `naive_bus`, with an optional wait-state engine that throttles grants. It sits behind the bus router as a generic memory or peripheral stand-in. It lets the core-side bus masters be exercised against both zero-wait and multi-cycle responders. It decodes only the word index of the address; range decoding is done by the router.

## Interface

**Parameters**
- `ADDR_BITS`, default 12: word-address bits. Capacity is 2^ADDR_BITS 32-bit words. The index is `addr[ADDR_BITS+1:2]`.
- `WAIT_CYCLES`, default 2: extra cycles before a grant, range 0..15. Used only with the wait-state feature.

**Ports**
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous reset, active-high.
- `bus_slave`, `naive_bus.slave`, –: the responder port.
  - Inputs: `rd_req`, `rd_be[3:0]`, `rd_addr[31:0]`, `wr_req`, `wr_be[3:0]`, `wr_addr[31:0]`, `wr_data[31:0]`.
  - Outputs: `rd_gnt`, `wr_gnt`, `rd_data[31:0]`.

## Operation

**Bus rules**
- A master holds `req`, `addr`, `be` and `wdata` constant until it sees `gnt`. A `req` without `gnt` is a stall.
- At most one grant per cycle, because the array is single-port.
- When both requests are pending in IDLE, the read wins. The write is served in a following grant.

**Grant cycle effects**
- Read grant: at the granting edge, `rd_data` captures the full 32-bit word at `rd_addr`. `rd_be` is ignored, and the master extracts the bytes it needs.
- Write grant: at the granting edge, byte lane i is written with `wr_data[8i+7:8i]` only where `wr_be[i]=1`. `wr_be=0` is granted and writes nothing.
- `rd_data` holds its value until the next read grant. Masters latch it one cycle after the grant.

**Wait-state FSM** (feature compiled in, `WAIT_CYCLES>0`): states IDLE, RD_WAIT, WR_WAIT, with a 4-bit counter `cnt`.
- IDLE, `rd_req=1`: `cnt<=WAIT_CYCLES`, go to RD_WAIT. No grant this cycle.
- IDLE, `rd_req=0` and `wr_req=1`: `cnt<=WAIT_CYCLES`, go to WR_WAIT.
- RD_WAIT or WR_WAIT, matching `req=1`:
  - If `cnt>1`, decrement.
  - If `cnt==1`, assert the matching `gnt` combinationally this cycle and return to IDLE at the edge.
- RD_WAIT or WR_WAIT, matching `req` drops: abort to IDLE with no array access and no `rd_data` change.
- `WAIT_CYCLES=0`: the FSM stays in IDLE and grants combinationally, with read priority.

**Out-of-capacity addresses**
- Upper address bits above `ADDR_BITS+1` are ignored, so accesses alias.

## Timing

**Reset values**
- `rd_gnt=0`, `wr_gnt=0`, `rd_data=32'h0`, state IDLE, `cnt=0`.
- Array contents are not reset and are preserved across reset.

**Grant and data latency**
- `gnt` is a combinational function of state, `cnt` and `req`. No registered delay.
- Read-data latency: `rd_data` is valid on the cycle after `rd_gnt`.
- With wait states, the first grant comes WAIT_CYCLES+1 cycles after `req` rises: 1 cycle in IDLE, then WAIT_CYCLES−1 cycles counting, then the granting cycle.
- Back-to-back requests of the same type each pay the full wait, because every grant returns to IDLE.

**Ordering and hazards**
- A write granted at edge N is visible to a read granted at edge N+1 or later.
- A read and a write never complete on the same edge.

**Reset mid-operation**
- `rst` during RD_WAIT or WR_WAIT drops the grants immediately and asynchronously.
- No array write occurs, and `rd_data` is cleared.

**Requests during the granting cycle**
- A `wr_req` arriving during a read-granting cycle starts its own wait in the next cycle, from IDLE.

## Configuration

`NAIVE_RAM_WAIT_STATE_EN` controls the wait-state engine.

- **Defined:** the wait-state FSM and counter are built and honour `WAIT_CYCLES`.
- **Undefined:** no FSM or counter is built and `WAIT_CYCLES` is ignored.
  - `rd_gnt = rd_req`.
  - `wr_gnt = wr_req & ~rd_req`.
  - Every access completes in the cycle it is requested; reads deliver `rd_data` on the following cycle.

## Test plan

1. **Zero-wait write then read.** Macro off. Write `0xDEADBEEF` to `0x10` with `be=4'hF`, then read `0x10`. Required: `wr_gnt` in the same cycle as the request; `rd_data=0xDEADBEEF` one cycle after `rd_gnt`.
2. **Byte-enable masking.** Preload `0x11223344` at `0x20`, then write `0xAABBCCDD` with `be=4'b0101`. Required: a subsequent read returns `0x11BB33DD`.
3. **Wait states.** Macro on, `WAIT_CYCLES=3`. Hold `rd_req` at `0x20`. Required: `rd_gnt` high only on the 4th cycle after `req` rises; data appears on the 5th; `rd_data` stays unchanged on cycles 1–4.
4. **Simultaneous requests.** Assert `rd_req` and `wr_req` in the same cycle. Required: read granted first, write granted after a further full wait (zero-wait: the next cycle); never both in one cycle.
5. **Abort mid-wait.** Drop `wr_req` while in WR_WAIT with `cnt=2`. Required: no grant, memory unchanged, state returns to IDLE.
6. **Reset mid-wait.** Pulse `rst` during RD_WAIT. Required: `rd_gnt=0` and `rd_data=0` immediately; a new read after release pays the full wait and returns the preserved array contents.
